// File: rtl/cronometro_ctrl.sv
// cronometro_ctrl: button conditioning and run/lap/pause sequencer for the
// stopwatch datapath. Three raw buttons are synchronized, debounced and turned
// into single-cycle press pulses. A four-state FSM turns those pulses into
// count enable, a gated count tick, a clear pulse and a lap display freeze.

// Conditioning for one raw push-button: 2-FF synchronizer, debounce counter,
// and a one-cycle pulse on each debounced rising edge.
module cronometro_btn_cond #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clkin,
    input  logic reset,
    input  logic btn,
    output logic press
);

    // Wide enough to hold DEB_CYCLES-1, the last count before the level flips.
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic             sync_a;
    logic             sync_s;
    logic [DEB_W-1:0] deb_cnt;
    logic             db;
    logic             db_q;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b0;
            sync_s <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_s <= sync_a;
        end
    end

    // Accept a new level only after it has held for DEB_CYCLES consecutive cycles.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            deb_cnt <= '0;
            db      <= 1'b0;
        end else if (sync_s == db) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            db      <= sync_s;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    // One pulse per debounced press; holding or releasing gives nothing more.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            db_q  <= 1'b0;
            press <= 1'b0;
        end else begin
            db_q  <= db;
            press <= db & ~db_q;
        end
    end

endmodule

// Top-level control sequencer.
module cronometro_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int TICK_DIV   = 500000
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clr,
    output logic       cnt_en,
    output logic       cnt_tick,
    output logic       cnt_clr,
    output logic       disp_freeze,
    output logic [1:0] state
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    state_t              state_r;
    state_t              state_nx;
    logic                clr_take;
    logic                press_start;
    logic                press_lap;
    logic                press_clr;
    logic [TICK_W-1:0]   div;

    // RUN and LAP are the two states in which the datapath counts.
    function automatic logic is_counting(input state_t s);
        return (s == RUN) || (s == LAP);
    endfunction

    cronometro_btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_start (
        .clkin (clkin),
        .reset (reset),
        .btn   (btn_start),
        .press (press_start)
    );

    cronometro_btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_lap (
        .clkin (clkin),
        .reset (reset),
        .btn   (btn_lap),
        .press (press_lap)
    );

    cronometro_btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_clr (
        .clkin (clkin),
        .reset (reset),
        .btn   (btn_clr),
        .press (press_clr)
    );

    // Next-state selection: clr beats start beats lap, but a press the current
    // state ignores falls through to the next lower-priority press.
    always_comb begin
        state_nx = state_r;
        clr_take = 1'b0;
        case (state_r)
            IDLE: begin
                if (press_clr) begin
                    clr_take = 1'b1;
                end else if (press_start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (press_start) begin
                    state_nx = PAUSE;
                end else if (press_lap) begin
                    state_nx = LAP;
                end
            end
            LAP: begin
                if (press_start) begin
                    state_nx = PAUSE;
                end else if (press_lap) begin
                    state_nx = RUN;
                end
            end
            PAUSE: begin
                if (press_clr) begin
                    state_nx = IDLE;
                    clr_take = 1'b1;
                end else if (press_start) begin
                    state_nx = RUN;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register with outputs decoded from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_en      <= 1'b0;
            disp_freeze <= 1'b0;
            cnt_clr     <= 1'b0;
        end else begin
            state_r     <= state_nx;
            cnt_en      <= is_counting(state_nx);
            disp_freeze <= (state_nx == LAP);
            cnt_clr     <= clr_take;
        end
    end

    // Tick divider: advances only on cycles that stay in a counting state, so a
    // tick due on the way into PAUSE is held back and phase survives the pause.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            div      <= '0;
            cnt_tick <= 1'b0;
        end else if ((state_r == IDLE) || cnt_clr) begin
            div      <= '0;
            cnt_tick <= 1'b0;
        end else if (is_counting(state_r) && is_counting(state_nx)) begin
            if (div == TICK_W'(TICK_DIV - 1)) begin
                div      <= '0;
                cnt_tick <= 1'b1;
            end else begin
                div      <= div + TICK_W'(1);
                cnt_tick <= 1'b0;
            end
        end else begin
            cnt_tick <= 1'b0;
        end
    end

    assign state = state_r;

endmodule
